dram_sc_rdfill_asm: RTL and testbench



---
 rtl/dram_sc_rdfill_asm_pkg.sv | 31 +++
 rtl/dram_sc_rdfill_asm_if.sv | 37 +++
 rtl/dram_sc_rdfill_asm_align.sv | 42 ++++
 rtl/dram_sc_rdfill_asm.sv | 166 ++++++++++++++++
 tb/tb_dram_sc_rdfill_asm.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_sc_rdfill_asm_pkg.sv
// dram_sc_fill_pkg: shared constants and types for the DRAM read-return
// fill assembler (dram_sc_rdfill_asm).
//   - chunk/ECC/request-id widths of the DRAM return path
//   - line_t: one assembled 64-byte fill line (4 x 128-bit chunks + ECC + errs)
//   - asm_state_e: assembly register state
// Optional feature macro used by the design: DRAM_FILL_ECC_STORE_EN.
package dram_sc_fill_pkg;

  localparam int CHUNK_W     = 128;
  localparam int CHUNK_ECC_W = 28;
  localparam int REQ_ID_W    = 3;
  localparam int CHUNK_ID_W  = 2;
  // Fixed by the 64B line over a 128-bit return path.
  localparam int CHUNKS      = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_e;

  // Chunk n of a line sits in data[n] / ecc[n], so the packed data vector
  // places chunk n at bits [128n+127:128n].
  typedef struct packed {
    logic [REQ_ID_W-1:0]                    req_id;
    logic [CHUNKS-1:0][CHUNK_W-1:0]         data;
    logic [CHUNKS-1:0][CHUNK_ECC_W-1:0]     ecc;
    logic                                   secc;
    logic                                   mecc;
  } line_t;

endpackage

// File: rtl/dram_sc_rdfill_asm_if.sv
// dram_sc_rdfill_asm_if: completed-line fill interface towards sctag/scbuf.
// Handshake: fill_vld is high while a completed line sits at the head of the
// line buffer; the head fields are stable until the consumer raises fill_ack
// in a cycle where fill_vld is high, which pops that line. fill_ack while
// fill_vld is low has no effect.
// Signals:
//   fill_vld, fill_ack              valid/ack handshake
//   fill_req_id, fill_data, fill_ecc head line contents
//   fill_secc, fill_mecc             OR of per-chunk error flags of the head line
//   fill_ovf_err, fill_proto_err     sticky error flags (cleared by reset only)
// Modports: master = assembler (producer), slave = consumer.
interface dram_sc_rdfill_asm_if;
  import dram_sc_fill_pkg::*;

  logic                          fill_vld;
  logic                          fill_ack;
  logic [REQ_ID_W-1:0]           fill_req_id;
  logic [CHUNKS*CHUNK_W-1:0]     fill_data;
  logic [CHUNKS*CHUNK_ECC_W-1:0] fill_ecc;
  logic                          fill_secc;
  logic                          fill_mecc;
  logic                          fill_ovf_err;
  logic                          fill_proto_err;

  modport master (
    output fill_vld, fill_req_id, fill_data, fill_ecc,
    output fill_secc, fill_mecc, fill_ovf_err, fill_proto_err,
    input  fill_ack
  );

  modport slave (
    input  fill_vld, fill_req_id, fill_data, fill_ecc,
    input  fill_secc, fill_mecc, fill_ovf_err, fill_proto_err,
    output fill_ack
  );

endinterface

// File: rtl/dram_sc_rdfill_asm_align.sv
// dram_sc_fill_align: delays the r0 read-return control (valid, chunk id,
// request id) by two cycles so it lines up with the r2 data/ECC/error bits.
// Ports:
//   clk, rst_l           clock, synchronous active-low reset
//   vld_r0/chunk_id_r0/req_id_r0   control at r0 timing
//   vld_r2/chunk_id_r2/req_id_r2   same control at r2 timing
// Only the valid bits are reset; id fields are don't-care while invalid.
module dram_sc_fill_align
  import dram_sc_fill_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  vld_r0,
  input  logic [CHUNK_ID_W-1:0] chunk_id_r0,
  input  logic [REQ_ID_W-1:0]   req_id_r0,
  output logic                  vld_r2,
  output logic [CHUNK_ID_W-1:0] chunk_id_r2,
  output logic [REQ_ID_W-1:0]   req_id_r2
);

  logic                  vld_r1;
  logic [CHUNK_ID_W-1:0] chunk_id_r1;
  logic [REQ_ID_W-1:0]   req_id_r1;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      vld_r1 <= 1'b0;
      vld_r2 <= 1'b0;
    end else begin
      vld_r1 <= vld_r0;
      vld_r2 <= vld_r1;
    end
  end

  always_ff @(posedge clk) begin
    chunk_id_r1 <= chunk_id_r0;
    chunk_id_r2 <= chunk_id_r1;
    req_id_r1   <= req_id_r0;
    req_id_r2   <= req_id_r1;
  end

endmodule

// File: rtl/dram_sc_rdfill_asm.sv
// dram_sc_rdfill_asm: read-return fill assembler between the DRAM-to-L2
// repeater and scbuf/sctag. Aligns r0 control to r2 data, gathers four
// 128-bit chunks into a 64-byte line, and queues completed lines in a
// NUM_LINES-entry buffer presented through a valid/ack interface.
// Ports:
//   rclk, rst_l                      clock, synchronous active-low reset
//   dram_sctag_*_r0_buf              chunk valid / chunk id / request id (r0)
//   dram_scbuf_data_r2_buf, _ecc_    chunk data and ECC (r2)
//   dram_sctag_secc/mecc_err_r2_buf  per-chunk error flags (r2)
//   fill                             dram_sc_rdfill_asm_if.master fill port
//   dbg_state                        assembly register state
// Macro DRAM_FILL_ECC_STORE_EN: when defined, chunk ECC is stored and
// presented on fill_ecc; otherwise fill_ecc is 0 and the ECC input is unused.
module dram_sc_rdfill_asm
  import dram_sc_fill_pkg::*;
#(
  parameter int NUM_LINES = 2
) (
  input  logic                   rclk,
  input  logic                   rst_l,
  input  logic                   dram_sctag_data_vld_r0_buf,
  input  logic [CHUNK_ID_W-1:0]  dram_sctag_chunk_id_r0_buf,
  input  logic [REQ_ID_W-1:0]    dram_sctag_rd_req_id_r0_buf,
  input  logic [CHUNK_W-1:0]     dram_scbuf_data_r2_buf,
  input  logic [CHUNK_ECC_W-1:0] dram_scbuf_ecc_r2_buf,
  input  logic                   dram_sctag_secc_err_r2_buf,
  input  logic                   dram_sctag_mecc_err_r2_buf,
  dram_sc_rdfill_asm_if.master   fill,
  output asm_state_e             dbg_state
);

  localparam int PTR_W = $clog2(NUM_LINES);
  localparam int CNT_W = PTR_W + 1;

  logic                  vld_r2;
  logic [CHUNK_ID_W-1:0] chunk_id_r2;
  logic [REQ_ID_W-1:0]   req_id_r2;

  dram_sc_fill_align u_align (
    .clk         (rclk),
    .rst_l       (rst_l),
    .vld_r0      (dram_sctag_data_vld_r0_buf),
    .chunk_id_r0 (dram_sctag_chunk_id_r0_buf),
    .req_id_r0   (dram_sctag_rd_req_id_r0_buf),
    .vld_r2      (vld_r2),
    .chunk_id_r2 (chunk_id_r2),
    .req_id_r2   (req_id_r2)
  );

  logic [CHUNK_ECC_W-1:0] ecc_in;
`ifdef DRAM_FILL_ECC_STORE_EN
  assign ecc_in = dram_scbuf_ecc_r2_buf;
`else
  logic ecc_in_unused;
  assign ecc_in_unused = ^dram_scbuf_ecc_r2_buf;
  assign ecc_in        = '0;
`endif

  // ---------------- assembly register ----------------
  asm_state_e        state_q, state_d;
  line_t             asm_q, asm_d;
  logic [CHUNKS-1:0] mask_q, mask_d;
  logic              complete;
  logic              proto_hit;

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    mask_d    = mask_q;
    complete  = 1'b0;
    proto_hit = 1'b0;
    if (vld_r2) begin
      if (state_q == IDLE || req_id_r2 != asm_q.req_id) begin
        // Fresh line; a req_id change mid-line abandons the partial line.
        proto_hit    = (state_q == COLLECT);
        asm_d.req_id = req_id_r2;
        asm_d.secc   = dram_sctag_secc_err_r2_buf;
        asm_d.mecc   = dram_sctag_mecc_err_r2_buf;
        mask_d       = '0;
      end else begin
        proto_hit  = mask_q[chunk_id_r2];
        asm_d.secc = asm_q.secc | dram_sctag_secc_err_r2_buf;
        asm_d.mecc = asm_q.mecc | dram_sctag_mecc_err_r2_buf;
      end
      asm_d.data[chunk_id_r2] = dram_scbuf_data_r2_buf;
      asm_d.ecc[chunk_id_r2]  = ecc_in;
      mask_d[chunk_id_r2]     = 1'b1;
      state_d                 = COLLECT;
      // The completing chunk goes straight into the pushed line (asm_d).
      if (&mask_d) begin
        complete = 1'b1;
        state_d  = IDLE;
        mask_d   = '0;
      end
    end
  end

  always_ff @(posedge rclk) begin
    asm_q <= asm_d;
  end

  // ---------------- line buffer ----------------
  line_t             mem [NUM_LINES];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, push, pop, ovf_hit;
  logic              ovf_err, proto_err;

  assign full    = (count == CNT_W'(NUM_LINES));
  assign pop     = fill.fill_vld & fill.fill_ack;
  // A pop in the same cycle frees the head slot, so a full buffer still
  // accepts the line; with wr_ptr == rd_ptr the new line lands behind the
  // remaining entries.
  assign push    = complete & (~full | pop);
  assign ovf_hit = complete & full & ~pop;

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (push) begin
        mem[wr_ptr] <= asm_d;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_hit)   ovf_err   <= 1'b1;
      if (proto_hit) proto_err <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  line_t head;
  assign head = mem[rd_ptr];

  assign fill.fill_vld       = (count != '0);
  assign fill.fill_req_id    = head.req_id;
  assign fill.fill_data      = head.data;
  assign fill.fill_secc      = head.secc;
  assign fill.fill_mecc      = head.mecc;
  assign fill.fill_ovf_err   = ovf_err;
  assign fill.fill_proto_err = proto_err;
`ifdef DRAM_FILL_ECC_STORE_EN
  assign fill.fill_ecc       = head.ecc;
`else
  logic head_ecc_unused;
  assign head_ecc_unused     = ^head.ecc;
  assign fill.fill_ecc       = '0;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_sc_rdfill_asm.sv
// tb_dram_sc_rdfill_asm: randomized self-checking bench for dram_sc_rdfill_asm.
// Driver issues chunks at r0 and replays their payload at r2 two cycles later;
// a chunk-level reference model turns r2 chunks into expected lines in exp_q,
// and a negedge monitor pops/compares on every fill_vld & fill_ack.
// Honours DRAM_FILL_ECC_STORE_EN for the expected fill_ecc.
module tb_dram_sc_rdfill_asm;
  import dram_sc_fill_pkg::*;

  localparam int NUM_LINES = 2;

  typedef struct {
    logic         v;
    logic [2:0]   rid;
    logic [1:0]   cid;
    logic [127:0] data;
    logic [27:0]  ecc;
    logic         secc;
    logic         mecc;
  } chunk_t;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rst_l = 1'b0;
  always #5 rclk = ~rclk;

  logic         dram_sctag_data_vld_r0_buf;
  logic [1:0]   dram_sctag_chunk_id_r0_buf;
  logic [2:0]   dram_sctag_rd_req_id_r0_buf;
  logic [127:0] dram_scbuf_data_r2_buf;
  logic [27:0]  dram_scbuf_ecc_r2_buf;
  logic         dram_sctag_secc_err_r2_buf;
  logic         dram_sctag_mecc_err_r2_buf;
  asm_state_e   dbg_state;

  dram_sc_rdfill_asm_if fill_if ();

  dram_sc_rdfill_asm #(.NUM_LINES(NUM_LINES)) dut (
    .rclk                        (rclk),
    .rst_l                       (rst_l),
    .dram_sctag_data_vld_r0_buf  (dram_sctag_data_vld_r0_buf),
    .dram_sctag_chunk_id_r0_buf  (dram_sctag_chunk_id_r0_buf),
    .dram_sctag_rd_req_id_r0_buf (dram_sctag_rd_req_id_r0_buf),
    .dram_scbuf_data_r2_buf      (dram_scbuf_data_r2_buf),
    .dram_scbuf_ecc_r2_buf       (dram_scbuf_ecc_r2_buf),
    .dram_sctag_secc_err_r2_buf  (dram_sctag_secc_err_r2_buf),
    .dram_sctag_mecc_err_r2_buf  (dram_sctag_mecc_err_r2_buf),
    .fill                        (fill_if),
    .dbg_state                   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  line_t      exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_proto = 1'b0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  int         ack_mode = 0;   // 0: never ack, 1: always ack, 2: random ack
  chunk_t     p1, p2;         // chunks issued one / two cycles ago
  logic       cur_v = 1'b0;
  line_t      cur;
  logic [3:0] cur_have;
  line_t      mon_exp;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: one r2 chunk applied to the line being gathered.
  task automatic model_chunk(input chunk_t c);
    if (!cur_v || c.rid != cur.req_id) begin
      if (cur_v) exp_proto = 1'b1;
      cur        = '0;
      cur.req_id = c.rid;
      cur_have   = '0;
      cur_v      = 1'b1;
    end else if (cur_have[c.cid]) begin
      exp_proto = 1'b1;
    end
    cur.data[c.cid] = c.data;
`ifdef DRAM_FILL_ECC_STORE_EN
    cur.ecc[c.cid] = c.ecc;
`endif
    cur.secc = cur.secc | c.secc;
    cur.mecc = cur.mecc | c.mecc;
    cur_have[c.cid] = 1'b1;
    if (cur_have == 4'hF) begin
      if (exp_q.size() < NUM_LINES) exp_q.push_back(cur);
      else exp_ovf = 1'b1;
      cur_v = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic chunk_t mk(input logic v, input logic [2:0] rid, input logic [1:0] cid,
                                input logic s, input logic m);
    chunk_t c;
    c.v    = v;
    c.rid  = rid;
    c.cid  = cid;
    c.data = {$urandom, $urandom, $urandom, $urandom};
    c.ecc  = 28'($urandom);
    c.secc = s;
    c.mecc = m;
    return c;
  endfunction

  // One clock: c at r0, the chunk issued two cycles ago at r2.
  task automatic step(input chunk_t c, input logic rst);
    rst_l                       = ~rst;
    dram_sctag_data_vld_r0_buf  = c.v;
    dram_sctag_chunk_id_r0_buf  = c.cid;
    dram_sctag_rd_req_id_r0_buf = c.rid;
    dram_scbuf_data_r2_buf      = p2.data;
    dram_scbuf_ecc_r2_buf       = p2.ecc;
    dram_sctag_secc_err_r2_buf  = p2.secc;
    dram_sctag_mecc_err_r2_buf  = p2.mecc;
    case (ack_mode)
      0:       fill_if.fill_ack = 1'b0;
      1:       fill_if.fill_ack = 1'b1;
      default: fill_if.fill_ack = 1'($urandom_range(0, 1));
    endcase
    if (rst) fill_if.fill_ack = 1'b0;
    @(posedge rclk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_proto = 1'b0;
      cur_v     = 1'b0;
      p1.v      = 1'b0;
      c.v       = 1'b0;
    end else if (p2.v) begin
      model_chunk(p2);
    end
    p2 = p1;
    p1 = c;
  endtask

  task automatic idle(input int n);
    repeat (n) step(mk(1'b0, 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom)), 1'b0);
  endtask

  task automatic send(input logic [2:0] rid, input logic [1:0] cid, input logic s, input logic m);
    step(mk(1'b1, rid, cid, s, m), 1'b0);
  endtask

  task automatic do_reset();
    step(mk(1'b0, 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom)), 1'b1);
    chk("rst_fill_vld", fill_if.fill_vld, 1'b0);
    chk("rst_fill_req_id", fill_if.fill_req_id, 3'd0);
    chk("rst_fill_data", fill_if.fill_data, 512'd0);
    chk("rst_fill_ecc", fill_if.fill_ecc, 112'd0);
    chk("rst_fill_secc", fill_if.fill_secc, 1'b0);
    chk("rst_fill_mecc", fill_if.fill_mecc, 1'b0);
    chk("rst_fill_ovf_err", fill_if.fill_ovf_err, 1'b0);
    chk("rst_fill_proto_err", fill_if.fill_proto_err, 1'b0);
    chk("rst_dbg_state", dbg_state, IDLE);
  endtask

  // ---------------- monitor ----------------
  always @(negedge rclk) begin
    if (mon_en) begin
      chk("fill_vld", fill_if.fill_vld, exp_q.size() != 0);
      chk("fill_ovf_err", fill_if.fill_ovf_err, exp_ovf);
      chk("fill_proto_err", fill_if.fill_proto_err, exp_proto);
      if (fill_if.fill_vld === 1'b1 && fill_if.fill_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected req_id=%0h exp=none", fill_if.fill_req_id);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("fill_req_id", fill_if.fill_req_id, mon_exp.req_id);
          chk("fill_data", fill_if.fill_data, mon_exp.data);
          chk("fill_ecc", fill_if.fill_ecc, mon_exp.ecc);
          chk("fill_secc", fill_if.fill_secc, mon_exp.secc);
          chk("fill_mecc", fill_if.fill_mecc, mon_exp.mecc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] pat;
    chunk_t       c;
    pat = {16{8'h11}};
    p1  = mk(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    p2  = p1;
    fill_if.fill_ack = 1'b0;
    step(mk(1'b0, 3'd0, 2'd0, 1'b0, 1'b0), 1'b1);
    do_reset();
    mon_en = 1'b1;

    // In-order line, data = chunk# x 0x11.., no errors.
    ack_mode = 1;
    for (int i = 0; i < 4; i++) begin
      c = mk(1'b1, 3'd5, 2'(i), 1'b0, 1'b0);
      c.data = pat * 128'(i);
      step(c, 1'b0);
    end
    idle(4);

    // Out-of-order line 2,0,3,1 with mecc on chunk 3.
    send(3'd1, 2'd2, 1'b0, 1'b0);
    send(3'd1, 2'd0, 1'b0, 1'b0);
    send(3'd1, 2'd3, 1'b0, 1'b1);
    send(3'd1, 2'd1, 1'b0, 1'b0);
    idle(4);

    // Three lines with no ack: third is dropped, then drain.
    do_reset();
    ack_mode = 0;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++) send(3'(l), 2'(i), 1'b0, 1'b0);
    idle(4);
    ack_mode = 1;
    idle(4);

    // Full buffer, line completes in the ack cycle: no drop.
    do_reset();
    ack_mode = 0;
    for (int l = 3; l < 5; l++)
      for (int i = 0; i < 4; i++) send(3'(l), 2'(i), 1'($urandom), 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) send(3'd5, 2'(i), 1'b0, 1'b0);
    idle(1);
    ack_mode = 1;
    idle(1);
    ack_mode = 0;
    idle(3);
    ack_mode = 1;
    idle(5);

    // Duplicate chunk, then req_id switch mid-line.
    do_reset();
    send(3'd4, 2'd0, 1'b0, 1'b0);
    send(3'd4, 2'd1, 1'b0, 1'b0);
    send(3'd4, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(3'd6, 2'(i), 1'b0, 1'b0);
    idle(4);

    // Reset mid-line: stale mask bits must not complete the next line early.
    do_reset();
    send(3'd7, 2'd2, 1'b1, 1'b1);
    send(3'd7, 2'd3, 1'b1, 1'b1);
    idle(2);
    do_reset();
    send(3'd3, 2'd0, 1'b0, 1'b0);
    send(3'd3, 2'd1, 1'b0, 1'b0);
    idle(3);
    send(3'd3, 2'd2, 1'b0, 1'b0);
    send(3'd3, 2'd3, 1'b0, 1'b0);
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int         order[4];
      int         r;
      int         j;
      int         t;
      logic [2:0] rid;
      r = $urandom_range(0, 9);
      ack_mode = (r < 2) ? 0 : (r < 4) ? 1 : 2;
      rid = 3'($urandom);
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 19) == 0)
          send(rid ^ 3'($urandom_range(1, 7)), 2'($urandom), 1'b0, 1'b0);
        send(rid, 2'(order[k]), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 19) == 0)
          send(rid, 2'(order[k]), 1'($urandom), 1'b0);
      end
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    ack_mode = 1;
    idle(8);
    chk("drain_fill_vld", fill_if.fill_vld, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
